sram_ctrl: RTL and testbench

//  Bus-side initiator for the board's 256Kx16 asynchronous SRAM (512KB). Converts single 32-bit
//  bus requests (byte-enabled, little-endian) into two sequenced 16-bit SRAM accesses.

---
 rtl/sram_ctrl_pkg.sv | 26 ++
 rtl/sram_ctrl_dq.sv | 37 +++
 rtl/sram_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_sram_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared definitions for the 256Kx16 SRAM controller.
//   state_t  - sequencer states
//   HALF_LO / HALF_HI - halfword select values (SRAM_ADDR[0])
//   half_be / half_data - pick the byte enables / write data of one halfword
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  function automatic logic [1:0] half_be(input logic [3:0] be, input logic half);
    return half ? be[3:2] : be[1:0];
  endfunction

  function automatic logic [15:0] half_data(input logic [31:0] data, input logic half);
    return half ? data[31:16] : data[15:0];
  endfunction

endpackage

// File: rtl/sram_ctrl_dq.sv
// sram_ctrl_dq: SRAM data-bus tristate driver and read capture register.
// Ports:
//   clk, nreset       - clock, synchronous active-low reset
//   oe, wdata16       - drive enable and halfword to place on dq
//   clr               - clear the capture register (start of a new access)
//   cap_en, cap_half  - capture dq into the selected half of cap_data
//   cap_be            - byte enables of that half; disabled lanes capture 0
//   cap_data          - assembled 32-bit read word
//   dq                - SRAM data bus
module sram_ctrl_dq (
  input  logic        clk,
  input  logic        nreset,
  input  logic        oe,
  input  logic [15:0] wdata16,
  input  logic        clr,
  input  logic        cap_en,
  input  logic        cap_half,
  input  logic [1:0]  cap_be,
  output logic [31:0] cap_data,
  inout  wire  [15:0] dq
);

  logic [15:0] lane_mask;

  assign dq        = oe ? wdata16 : {16{1'bz}};
  assign lane_mask = {{8{cap_be[1]}}, {8{cap_be[0]}}};

  always_ff @(posedge clk) begin
    if (!nreset || clr) begin
      cap_data <= '0;
    end else if (cap_en) begin
      if (cap_half) cap_data[31:16] <= dq & lane_mask;
      else          cap_data[15:0]  <= dq & lane_mask;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit bus initiator for a 256Kx16 asynchronous SRAM. Each bus
// request becomes two sequenced halfword accesses (low half first).
// Ports:
//   clk, nreset             - clock, synchronous active-low reset
//   bus_addr/rd/wr/be/wdata - request (held until bus_ack; rd&wr = write)
//   bus_rdata, bus_ack      - read data and one-cycle completion pulse
//   SRAM_*                  - SRAM pins; all strobes active low, DQ tristate
// Parameter WAIT_STATES: strobe width is WAIT_STATES+1 clocks.
// Build option SRAM_CTRL_SKIP_EN: halves whose two byte enables are both 0
// are skipped with no SRAM cycle.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [18:0] bus_addr,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [3:0]  bus_be,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_STATES);

  state_t        state, state_nx;
  logic          half, half_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [16:0]   word, word_nx;
  logic [3:0]    be_q, be_nx;
  logic [31:0]   wdata_q, wdata_nx;
  logic          is_wr, wr_nx;

  logic          drive, drive_nx;
  logic [15:0]   dq_out, dq_out_nx;
  logic [17:0]   addr_nx;
  logic          ce_n_nx, we_n_nx, oe_n_nx, ub_n_nx, lb_n_nx, ack_nx;
  logic [31:0]   rdata_nx;

  logic          accept, cap_en, hi_needed, active;
  logic [1:0]    be_cur, be_next;
  logic [31:0]   cap_data;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^bus_addr[1:0];
  assign accept = (state == ST_IDLE) && (bus_rd || bus_wr);
  assign be_cur = half_be(be_q, half);

`ifdef SRAM_CTRL_SKIP_EN
  assign hi_needed = (be_q[3:2] != 2'b00);
`else
  assign hi_needed = 1'b1;
`endif

  // Sequencing. Pin outputs are registered from the *next* state so they
  // are glitch-free yet line up cycle-for-cycle with the state they belong to.
  always_comb begin
    state_nx = state;
    half_nx  = half;
    cnt_nx   = cnt;
    word_nx  = word;
    be_nx    = be_q;
    wdata_nx = wdata_q;
    wr_nx    = is_wr;
    cap_en   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          word_nx  = bus_addr[18:2];
          be_nx    = bus_be;
          wdata_nx = bus_wdata;
          wr_nx    = bus_wr;
          half_nx  = HALF_LO;
          state_nx = ST_SETUP;
`ifdef SRAM_CTRL_SKIP_EN
          if (bus_be[1:0] == 2'b00) begin
            half_nx  = HALF_HI;
            state_nx = (bus_be[3:2] == 2'b00) ? ST_DONE : ST_SETUP;
          end
`endif
        end
      end
      ST_SETUP: begin
        cnt_nx   = '0;
        state_nx = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt == CNT_LAST) begin
          cap_en   = !is_wr;
          state_nx = ST_HOLD;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ST_HOLD: begin
        if (half == HALF_LO && hi_needed) begin
          half_nx  = HALF_HI;
          state_nx = ST_SETUP;
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase

    active    = (state_nx == ST_SETUP) || (state_nx == ST_STROBE) || (state_nx == ST_HOLD);
    be_next   = half_be(be_nx, half_nx);
    addr_nx   = active ? {word_nx, half_nx} : SRAM_ADDR;
    ce_n_nx   = !active;
    ub_n_nx   = !(active && be_next[1]);
    lb_n_nx   = !(active && be_next[0]);
    we_n_nx   = !((state_nx == ST_STROBE) && wr_nx);
    oe_n_nx   = !((state_nx == ST_STROBE) && !wr_nx);
    drive_nx  = active && wr_nx;
    dq_out_nx = half_data(wdata_nx, half_nx);
    ack_nx    = (state_nx == ST_DONE);

    // A read going straight from IDLE to DONE (all lanes skipped) never
    // touched the capture register, so its result is forced to zero.
    rdata_nx = bus_rdata;
    if (state_nx == ST_DONE && !wr_nx)
      rdata_nx = (state == ST_IDLE) ? '0 : cap_data;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      half      <= HALF_LO;
      cnt       <= '0;
      word      <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      is_wr     <= 1'b0;
      drive     <= 1'b0;
      dq_out    <= '0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      state     <= state_nx;
      half      <= half_nx;
      cnt       <= cnt_nx;
      word      <= word_nx;
      be_q      <= be_nx;
      wdata_q   <= wdata_nx;
      is_wr     <= wr_nx;
      drive     <= drive_nx;
      dq_out    <= dq_out_nx;
      SRAM_ADDR <= addr_nx;
      SRAM_CE_N <= ce_n_nx;
      SRAM_WE_N <= we_n_nx;
      SRAM_OE_N <= oe_n_nx;
      SRAM_UB_N <= ub_n_nx;
      SRAM_LB_N <= lb_n_nx;
      bus_ack   <= ack_nx;
      bus_rdata <= rdata_nx;
    end
  end

  sram_ctrl_dq u_dq (
    .clk      (clk),
    .nreset   (nreset),
    .oe       (drive),
    .wdata16  (dq_out),
    .clr      (accept),
    .cap_en   (cap_en),
    .cap_half (half),
    .cap_be   (be_cur),
    .cap_data (cap_data),
    .dq       (SRAM_DQ)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: sram_ctrl with a behavioural 256Kx16 async SRAM and a
// word/byte-level reference memory. Build option SRAM_CTRL_SKIP_EN selects
// the expected skip behaviour.
module tb_sram_ctrl;

  localparam int unsigned WS = 1;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [18:0] bus_addr = '0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic [3:0]  bus_be = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.WAIT_STATES(WS)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .bus_addr  (bus_addr),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_WE_N (we_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n)
  );

  // Behavioural async SRAM.
  logic [15:0] sram [0:262143];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? sram[sram_addr] : {16{1'bz}};
  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) sram[sram_addr][7:0]  <= sram_dq[7:0];
      if (!ub_n) sram[sram_addr][15:8] <= sram_dq[15:8];
    end
  end

  // Pin monitor.
  int unsigned contention = 0;
  int unsigned ce_even = 0;
  int unsigned ce_odd = 0;
  logic        saw_top = 1'b0;
  always @(negedge clk) begin
    if (!oe_n && !we_n) contention++;
    if (!ce_n) begin
      if (sram_addr[0]) ce_odd++;
      else              ce_even++;
      if (sram_addr == 18'h3FFFF) saw_top = 1'b1;
    end
  end

  // Reference model: 32-bit words, byte-granular updates.
  logic [31:0] ref_mem [logic [16:0]];

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] ref_read(input logic [16:0] w, input logic [3:0] be);
    logic [31:0] v;
    v = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    return v & lane_mask(be);
  endfunction

  function automatic void ref_write(input logic [16:0] w, input logic [3:0] be,
                                    input logic [31:0] d);
    logic [31:0] v;
    logic [31:0] m;
    v = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    m = lane_mask(be);
    ref_mem[w] = (v & ~m) | (d & m);
  endfunction

  // Each SRAM halfword cycle is SETUP + strobe + HOLD; DONE adds one more.
  function automatic int unsigned exp_latency(input logic [3:0] be);
    int unsigned halves;
`ifdef SRAM_CTRL_SKIP_EN
    halves = 0;
    if (be[1:0] != 2'b00) halves++;
    if (be[3:2] != 2'b00) halves++;
`else
    halves = 2;
`endif
    return (halves == 0) ? 1 : halves * (WS + 3) + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [18:0] addr, input logic [3:0] be, input logic [31:0] wd);
    int unsigned n;
    logic [31:0] prev;
    @(posedge clk); #1;
    prev      = bus_rdata;
    bus_addr  = addr;
    bus_be    = be;
    bus_wdata = wd;
    bus_rd    = rd;
    bus_wr    = wr;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus_ack && n < 40);
    bus_rd = 1'b0;
    bus_wr = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'(exp_latency(be)));
    if (wr) begin
      ref_write(addr[18:2], be, wd);
      check({tag, "_rdata_hold"}, bus_rdata, prev);
    end else begin
      check({tag, "_rdata"}, bus_rdata, ref_read(addr[18:2], be));
    end
    @(posedge clk); #1;
    check({tag, "_ack_pulse"}, {31'b0, bus_ack}, 32'h0);
  endtask

  function automatic logic [18:0] pool_addr(input int unsigned i);
    logic [16:0] w;
    w = (i < 8) ? 17'(i) : 17'(17'h1FFF0 + i);
    return {w, 2'b00};
  endfunction

  initial begin
    int unsigned e0, o0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ce_n", {31'b0, ce_n}, 32'h1);
    check("rst_we_n", {31'b0, we_n}, 32'h1);
    check("rst_oe_n", {31'b0, oe_n}, 32'h1);
    check("rst_be_n", {30'b0, ub_n, lb_n}, 32'h3);
    check("rst_ack", {31'b0, bus_ack}, 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_addr", {14'b0, sram_addr}, 32'h0);
    nreset = 1'b1;

    // Fill the word pool so every later read has defined contents.
    for (int unsigned i = 0; i < 16; i++)
      access("fill", 1'b0, 1'b1, pool_addr(i), 4'hF, $urandom);

    // Full-word write / read
    access("t2_wr", 1'b0, 1'b1, 19'h00010, 4'hF, 32'h12345678);
    check("t2_sram8", {16'h0, sram[8]}, 32'h00005678);
    check("t2_sram9", {16'h0, sram[9]}, 32'h00001234);
    access("t2_rd", 1'b1, 1'b0, 19'h00010, 4'hF, 32'h0);
    check("t2_value", bus_rdata, 32'h12345678);

    // Partial byte enables at the top of memory
    saw_top = 1'b0;
    access("t3_wr_ff", 1'b0, 1'b1, 19'h7FFFC, 4'hF, 32'hFFFFFFFF);
    access("t3_wr_p", 1'b0, 1'b1, 19'h7FFFC, 4'b0101, 32'hAABBCCDD);
    access("t3_rd", 1'b1, 1'b0, 19'h7FFFC, 4'hF, 32'h0);
    check("t3_value", bus_rdata, 32'hFFBBFFDD);
    check("t3_addr_wrap", {31'b0, saw_top}, 32'h1);

    // Reset during write strobe (word 0x10 is never read back)
    @(posedge clk); #1;
    bus_addr = 19'h00040; bus_be = 4'hF; bus_wdata = 32'hDEADBEEF; bus_wr = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("t4_in_strobe", {31'b0, we_n}, 32'h0);
    nreset = 1'b0;
    @(posedge clk); #1;
    bus_wr = 1'b0;
    check("t4_we_n", {31'b0, we_n}, 32'h1);
    check("t4_ce_n", {31'b0, ce_n}, 32'h1);
    check("t4_oe_n", {31'b0, oe_n}, 32'h1);
    repeat (2) begin
      @(posedge clk); #1;
      check("t4_no_ack", {31'b0, bus_ack}, 32'h0);
    end
    nreset = 1'b1;
    access("t4_rd", 1'b1, 1'b0, 19'h00010, 4'hF, 32'h0);

    // rd and wr together behave as a write
    access("t5_both", 1'b1, 1'b1, 19'h00100, 4'hF, 32'hCAFEF00D);
    access("t5_rd", 1'b1, 1'b0, 19'h00100, 4'hF, 32'h0);
    check("t5_value", bus_rdata, 32'hCAFEF00D);

    // Unused halves
    e0 = ce_even; o0 = ce_odd;
    access("t6_hi", 1'b0, 1'b1, 19'h00200, 4'b1100, 32'h11223344);
`ifdef SRAM_CTRL_SKIP_EN
    check("t6_hi_even", 32'(ce_even - e0), 32'h0);
`else
    check("t6_hi_even", 32'(ce_even - e0), 32'(WS + 3));
`endif
    check("t6_hi_odd", 32'(ce_odd - o0), 32'(WS + 3));
    e0 = ce_even; o0 = ce_odd;
    access("t6_none", 1'b1, 1'b0, 19'h00004, 4'b0000, 32'h0);
`ifdef SRAM_CTRL_SKIP_EN
    check("t6_none_ce", 32'((ce_even - e0) + (ce_odd - o0)), 32'h0);
`else
    check("t6_none_ce", 32'((ce_even - e0) + (ce_odd - o0)), 32'(2 * (WS + 3)));
`endif

    // Randomised traffic over the pool
    for (int unsigned k = 0; k < 40; k++) begin
      int unsigned op;
      op = $urandom_range(0, 2);
      access("rnd", op != 1, op != 0, pool_addr($urandom_range(0, 15)),
             4'($urandom), $urandom);
    end

    check("no_contention", 32'(contention), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
